pwr_mode_seq: RTL and testbench

//   Power-mode sequencer for the switchable domain (VDD_2) of upf_demo.

---
 rtl/pwr_mode_seq.sv | 241 ++++++++++++++++++++++++
 tb/tb_pwr_mode_seq.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/pwr_mode_seq.sv
// -----------------------------------------------------------------------------
// pwr_mode_seq
//   Power-mode sequencer for the switchable domain (VDD_2). It lives in the
//   always-on domain and steps the domain through this order on power-down:
//   clock gate, isolation, retention save, power switch off.
//   Power-up runs the reverse order: power on, restore, release isolation,
//   restart the clock.
//   Completion (or a no-op request) is signalled with a one-cycle mode_ack_o.
//
// Ports
//   clk_i        clock
//   reset_i      synchronous, active-high reset (returns to ON immediately)
//   mode_req_i   request pulse; mode_i is sampled on the same edge
//   mode_i       requested mode: 1 = domain on, 0 = domain off
//   pwr_ack_i    power switch status: 1 = domain powered
//   mode_ack_o   one-cycle pulse: sequence complete or request was a no-op
//   busy_o       sequence in progress; requests are dropped while high
//   cur_mode_o   committed mode; updates together with mode_ack_o
//   clk_en_o     domain clock enable
//   iso_en_o     isolation enable
//   save_o       one-cycle retention save strobe
//   restore_o    one-cycle retention restore strobe
//   pwr_en_o     power switch enable
//   err_o        sticky pwr_ack timeout flag, cleared only by reset
// -----------------------------------------------------------------------------
module pwr_mode_seq #(
    parameter int SETTLE_CYC = 2,
    parameter int ISO_CYC    = 2,
    parameter int TIMEOUT    = 16,
    parameter int CNT_W      = 5
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic mode_req_i,
    input  logic mode_i,
    input  logic pwr_ack_i,
    output logic mode_ack_o,
    output logic busy_o,
    output logic cur_mode_o,
    output logic clk_en_o,
    output logic iso_en_o,
    output logic save_o,
    output logic restore_o,
    output logic pwr_en_o,
    output logic err_o
);

    typedef enum logic [3:0] {
        S_ON      = 4'd0,
        S_GATE    = 4'd1,
        S_ISO     = 4'd2,
        S_SAVE    = 4'd3,
        S_PDOWN   = 4'd4,
        S_DONE    = 4'd5,
        S_OFF     = 4'd6,
        S_PUP     = 4'd7,
        S_RESTORE = 4'd8,
        S_UNISO   = 4'd9,
        S_UNGATE  = 4'd10
    } state_e;

    // Hold counters count down to zero, so a hold of N cycles loads N-1.
    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] ISO_LD    = CNT_W'(ISO_CYC - 1);
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = '0;
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    // Saturating helpers: the counter must never wrap.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] v);
        return (v == CNT_ZERO) ? v : v - CNT_W'(1);
    endfunction

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_inc_d;
    logic [CNT_W-1:0] cnt_dec_d;
    logic             hold_done_s;
    logic             wait_expired_s;
    logic             mode_ack_q, busy_q, cur_mode_q, clk_en_q, iso_en_q;
    logic             save_q, restore_q, pwr_en_q, err_q;

    // Counter next values and terminal-count decodes.
    always_comb begin
        cnt_inc_d      = sat_inc(cnt_q);
        cnt_dec_d      = sat_dec(cnt_q);
        hold_done_s    = (cnt_q == CNT_ZERO);
        // cnt_q holds (cycles spent waiting - 1) when sampled, so TMO_LAST
        // marks the edge on which TIMEOUT cycles have elapsed.
        wait_expired_s = (cnt_q == TMO_LAST);
    end

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= S_ON;
            cnt_q      <= CNT_ZERO;
            mode_ack_q <= 1'b0;
            busy_q     <= 1'b0;
            cur_mode_q <= 1'b1;
            clk_en_q   <= 1'b1;
            iso_en_q   <= 1'b0;
            save_q     <= 1'b0;
            restore_q  <= 1'b0;
            pwr_en_q   <= 1'b1;
            err_q      <= 1'b0;
        end else begin
            // Strobes are single-cycle unless re-asserted below.
            mode_ack_q <= 1'b0;
            save_q     <= 1'b0;
            restore_q  <= 1'b0;
            case (state_q)
                S_ON: begin
                    if (mode_req_i && !mode_i) begin
                        state_q  <= S_GATE;
                        busy_q   <= 1'b1;
                        clk_en_q <= 1'b0;
                        cnt_q    <= SETTLE_LD;
                    end else if (mode_req_i) begin
                        mode_ack_q <= 1'b1;  // already on: no-op acknowledge
                    end else begin
                        state_q <= S_ON;
                    end
                end
                S_GATE: begin
                    if (hold_done_s) begin
                        state_q  <= S_ISO;
                        iso_en_q <= 1'b1;
                        cnt_q    <= ISO_LD;
                    end else begin
                        cnt_q <= cnt_dec_d;
                    end
                end
                S_ISO: begin
                    if (hold_done_s) begin
                        state_q <= S_SAVE;
                        save_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_dec_d;
                    end
                end
                S_SAVE: begin
                    state_q  <= S_PDOWN;
                    pwr_en_q <= 1'b0;
                    cnt_q    <= CNT_ZERO;
                end
                S_PDOWN: begin
                    // On timeout the domain is still treated as off.
                    if (!pwr_ack_i || wait_expired_s) begin
                        state_q    <= S_DONE;
                        mode_ack_q <= 1'b1;
                        cur_mode_q <= 1'b0;
                        err_q      <= err_q | pwr_ack_i;
                    end else begin
                        cnt_q <= cnt_inc_d;
                    end
                end
                S_OFF: begin
                    if (mode_req_i && mode_i) begin
                        state_q  <= S_PUP;
                        busy_q   <= 1'b1;
                        pwr_en_q <= 1'b1;
                        cnt_q    <= CNT_ZERO;
                    end else if (mode_req_i) begin
                        mode_ack_q <= 1'b1;  // already off: no-op acknowledge
                    end else begin
                        state_q <= S_OFF;
                    end
                end
                S_PUP: begin
                    if (pwr_ack_i) begin
                        state_q   <= S_RESTORE;
                        restore_q <= 1'b1;
                    end else if (wait_expired_s) begin
                        // Abort power-up: switch off again, keep isolation,
                        // skip restore and stay committed to off.
                        state_q    <= S_DONE;
                        pwr_en_q   <= 1'b0;
                        err_q      <= 1'b1;
                        mode_ack_q <= 1'b1;
                        cur_mode_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_inc_d;
                    end
                end
                S_RESTORE: begin
                    state_q <= S_UNISO;
                    cnt_q   <= ISO_LD;
                end
                S_UNISO: begin
                    if (hold_done_s) begin
                        state_q  <= S_UNGATE;
                        iso_en_q <= 1'b0;
                        cnt_q    <= SETTLE_LD;
                    end else begin
                        cnt_q <= cnt_dec_d;
                    end
                end
                S_UNGATE: begin
                    if (hold_done_s) begin
                        state_q    <= S_DONE;
                        clk_en_q   <= 1'b1;
                        mode_ack_q <= 1'b1;
                        cur_mode_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_dec_d;
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= cur_mode_q ? S_ON : S_OFF;
                end
                default: begin
                    // Illegal encoding: fall back to the safe powered state.
                    state_q    <= S_ON;
                    cnt_q      <= CNT_ZERO;
                    busy_q     <= 1'b0;
                    cur_mode_q <= 1'b1;
                    clk_en_q   <= 1'b1;
                    iso_en_q   <= 1'b0;
                    pwr_en_q   <= 1'b1;
                end
            endcase
        end
    end

    assign mode_ack_o = mode_ack_q;
    assign busy_o     = busy_q;
    assign cur_mode_o = cur_mode_q;
    assign clk_en_o   = clk_en_q;
    assign iso_en_o   = iso_en_q;
    assign save_o     = save_q;
    assign restore_o  = restore_q;
    assign pwr_en_o   = pwr_en_q;
    assign err_o      = err_q;

endmodule

// File: tb/tb_pwr_mode_seq.sv
// -----------------------------------------------------------------------------
// tb_pwr_mode_seq
//   Directed bench for pwr_mode_seq. Output vector bit order:
//   {mode_ack, busy, cur_mode, clk_en, iso_en, save, restore, pwr_en, err}
// -----------------------------------------------------------------------------
module tb_pwr_mode_seq;

    logic clk = 1'b0;
    logic reset, mode_req, mode, pwr_ack;
    logic mode_ack, busy, cur_mode, clk_en, iso_en, save, restore, pwr_en, err;
    logic [8:0] out_s;

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        logic       rst;
        logic       req;
        logic       md;
        logic       ack;
        logic [8:0] exp;
    } vec_t;

    vec_t tbl[64];
    int   n_vec = 0;

    localparam logic [8:0] V_RST  = 9'b0_0_1_1_0_0_0_1_0;
    localparam logic [8:0] V_NOPO = 9'b1_0_1_1_0_0_0_1_0;
    localparam logic [8:0] V_GATE = 9'b0_1_1_0_0_0_0_1_0;
    localparam logic [8:0] V_ISO  = 9'b0_1_1_0_1_0_0_1_0;
    localparam logic [8:0] V_SAVE = 9'b0_1_1_0_1_1_0_1_0;
    localparam logic [8:0] V_PDN  = 9'b0_1_1_0_1_0_0_0_0;
    localparam logic [8:0] V_DNDN = 9'b1_1_0_0_1_0_0_0_0;
    localparam logic [8:0] V_OFF  = 9'b0_0_0_0_1_0_0_0_0;
    localparam logic [8:0] V_NOPF = 9'b1_0_0_0_1_0_0_0_0;
    localparam logic [8:0] V_PUP  = 9'b0_1_0_0_1_0_0_1_0;
    localparam logic [8:0] V_REST = 9'b0_1_0_0_1_0_1_1_0;
    localparam logic [8:0] V_UNGT = 9'b0_1_0_0_0_0_0_1_0;
    localparam logic [8:0] V_UPDN = 9'b1_1_1_1_0_0_0_1_0;
    localparam logic [8:0] V_TMO  = 9'b1_1_0_0_1_0_0_0_1;
    localparam logic [8:0] V_OFFE = 9'b0_0_0_0_1_0_0_0_1;

    pwr_mode_seq #(
        .SETTLE_CYC(2), .ISO_CYC(2), .TIMEOUT(16), .CNT_W(5)
    ) dut (
        .clk_i      (clk),
        .reset_i    (reset),
        .mode_req_i (mode_req),
        .mode_i     (mode),
        .pwr_ack_i  (pwr_ack),
        .mode_ack_o (mode_ack),
        .busy_o     (busy),
        .cur_mode_o (cur_mode),
        .clk_en_o   (clk_en),
        .iso_en_o   (iso_en),
        .save_o     (save),
        .restore_o  (restore),
        .pwr_en_o   (pwr_en),
        .err_o      (err)
    );

    assign out_s = {mode_ack, busy, cur_mode, clk_en, iso_en, save, restore, pwr_en, err};

    always #5 clk = ~clk;

    task automatic add(input logic r, input logic q, input logic m, input logic a,
                       input logic [8:0] e);
        tbl[n_vec] = '{rst: r, req: q, md: m, ack: a, exp: e};
        n_vec++;
    endtask

    // Drive inputs on the falling edge, then settle just after the rising edge.
    task automatic step(input logic r, input logic q, input logic m, input logic a);
        @(negedge clk);
        reset = r; mode_req = q; mode = m; pwr_ack = a;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    initial begin
        reset = 1'b1; mode_req = 1'b0; mode = 1'b0; pwr_ack = 1'b1;

        // Reset and idle
        add(1'b1, 1'b0, 1'b0, 1'b1, V_RST);
        for (int i = 0; i < 5; i++) add(1'b0, 1'b0, 1'b0, 1'b1, V_RST);
        // No-op request in ON
        add(1'b0, 1'b1, 1'b1, 1'b1, V_NOPO);
        add(1'b0, 1'b0, 1'b0, 1'b1, V_RST);
        // Down sequence, pwr_ack falls 3 cycles after pwr_en; a dropped request on e2
        add(1'b0, 1'b1, 1'b0, 1'b1, V_GATE);
        add(1'b0, 1'b0, 1'b0, 1'b1, V_GATE);
        add(1'b0, 1'b1, 1'b1, 1'b1, V_ISO);
        add(1'b0, 1'b0, 1'b0, 1'b1, V_ISO);
        add(1'b0, 1'b0, 1'b0, 1'b1, V_SAVE);
        add(1'b0, 1'b0, 1'b0, 1'b1, V_PDN);
        add(1'b0, 1'b0, 1'b0, 1'b1, V_PDN);
        add(1'b0, 1'b0, 1'b0, 1'b1, V_PDN);
        add(1'b0, 1'b0, 1'b0, 1'b1, V_PDN);
        add(1'b0, 1'b0, 1'b0, 1'b0, V_DNDN);
        add(1'b0, 1'b0, 1'b0, 1'b0, V_OFF);
        // No-op request in OFF
        add(1'b0, 1'b1, 1'b0, 1'b0, V_NOPF);
        add(1'b0, 1'b0, 1'b0, 1'b0, V_OFF);
        // Up sequence, pwr_ack rises 2 cycles after pwr_en; a dropped request on e5
        add(1'b0, 1'b1, 1'b1, 1'b0, V_PUP);
        add(1'b0, 1'b0, 1'b0, 1'b0, V_PUP);
        add(1'b0, 1'b0, 1'b0, 1'b0, V_PUP);
        add(1'b0, 1'b0, 1'b0, 1'b1, V_REST);
        add(1'b0, 1'b0, 1'b0, 1'b1, V_PUP);
        add(1'b0, 1'b1, 1'b0, 1'b1, V_PUP);
        add(1'b0, 1'b0, 1'b0, 1'b1, V_UNGT);
        add(1'b0, 1'b0, 1'b0, 1'b1, V_UNGT);
        add(1'b0, 1'b0, 1'b0, 1'b1, V_UPDN);
        add(1'b0, 1'b0, 1'b0, 1'b1, V_RST);
        add(1'b0, 1'b0, 1'b0, 1'b1, V_RST);

        for (int i = 0; i < n_vec; i++) begin
            step(tbl[i].rst, tbl[i].req, tbl[i].md, tbl[i].ack);
            chk($sformatf("vec[%0d]", i), out_s, tbl[i].exp);
        end

        // Down with pwr_ack already low on PDOWN entry: leaves after one cycle
        step(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i < 5; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("pdown_entry", out_s, V_PDN);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("pdown_fast_done", out_s, V_DNDN);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("off_after_fast", out_s, V_OFF);

        // Power-up timeout with pwr_ack stuck low
        step(1'b0, 1'b1, 1'b1, 1'b0);
        chk("pup_entry", out_s, V_PUP);
        for (int i = 1; i < 16; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0);
            chk($sformatf("pup_wait[%0d]", i), out_s, V_PUP);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("pup_timeout", out_s, V_TMO);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0);
            chk($sformatf("err_sticky[%0d]", i), out_s, V_OFFE);
        end
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("noop_keeps_err", out_s, 9'b1_0_0_0_1_0_0_0_1);

        // Reset clears err; abort mid-ISO
        step(1'b1, 1'b0, 1'b0, 1'b1);
        chk("reset_clears_err", out_s, V_RST);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("in_iso", out_s, V_ISO);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        chk("reset_mid_iso", out_s, V_RST);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("idle_after_abort", out_s, V_RST);

        // Fresh down request must complete; pwr_ack follows pwr_en with a lag
        begin
            bit got_ack = 1'b0;
            step(1'b0, 1'b1, 1'b0, 1'b1);
            for (int i = 0; i < 40 && !got_ack; i++) begin
                step(1'b0, 1'b0, 1'b0, pwr_en);
                if (mode_ack) got_ack = 1'b1;
            end
            chk("redo_down_ack", {8'd0, got_ack}, 9'd1);
            chk("redo_down_state", out_s, V_DNDN);
            step(1'b0, 1'b0, 1'b0, 1'b0);
            chk("redo_off", out_s, V_OFF);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
